conv_pass_sequencer: RTL and testbench

- Sequences repeated passes of the standard-convolution engine so the processor issues one command per layer, not one handshake per input channel.
- Latches the layer configuration (bias, kernel size, output size, channel count) and drives the engine's ps_control line. Drives n_val, where 0 means the bias is accumulated and non-zero means prior partial sums are accumulated.
- Tracks the engine's pl_status handshake, counts passes, and flags a stalled engine. Sits between the processor register block and the conv/MAC/output-BRAM datapath.

---
 rtl/conv_pass_sequencer_if.sv | 43 ++++
 rtl/conv_pass_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pass_sequencer_if.sv
// Purpose : bundles the processor command/config, engine handshake and status
//           lines of the convolution pass sequencer.
// Ports   : slave = sequencer side, master = processor/engine side.
interface conv_pass_sequencer_if #(
    parameter int T = 32
);
    // processor command and layer configuration
    logic         go;
    logic         abort;
    logic [T-1:0] cfg_bias;
    logic [T-1:0] cfg_k;
    logic [T-1:0] cfg_c;
    logic [T-1:0] cfg_n;

    // engine handshake
    logic [T-1:0] ps_control;
    logic [T-1:0] pl_status;

    // latched layer parameters seen by the datapath
    logic [T-1:0] bias;
    logic [T-1:0] k_val;
    logic [T-1:0] c_val;
    logic [T-1:0] n_val;

    // status back to the processor
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic         host_grant;

    modport slave (
        input  go, abort, cfg_bias, cfg_k, cfg_c, cfg_n, pl_status,
        output ps_control, bias, k_val, c_val, n_val,
               busy, done, err, err_code, host_grant
    );

    modport master (
        output go, abort, cfg_bias, cfg_k, cfg_c, cfg_n, pl_status,
        input  ps_control, bias, k_val, c_val, n_val,
               busy, done, err, err_code, host_grant
    );
endinterface

// File: rtl/conv_pass_sequencer.sv
// Purpose     : runs one input-channel pass of the conv engine per cfg_n, driving
//               ps_control / n_val and watching pl_status, so a layer is one command.
// Latency     : go -> LOAD next cycle, ps_control rises one cycle later; all outputs registered.
// Backpressure: none on go (sampled only in IDLE/DONE/ERR); engine paced by pl_status,
//               a pass stuck in WAIT_SET for TMO_MAX+1 cycles ends the layer with a timeout.
// Ports: clk, reset (async, active-low), bus (slave modport: go/abort/cfg_* in,
//        ps_control/pl_status engine handshake, latched config and status out).
module conv_pass_sequencer #(
    parameter int               T       = 32,
    parameter int               TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_MAX = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_pass_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT_SET,
        S_CLEAR,
        S_DONE,
        S_ERR,
        S_CLEAR_ABORT
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [TMO_W-1:0] wd;
    logic [T-1:0]     n_lat;

    // registered outputs
    logic             ps_control_q;
    logic [T-1:0]     bias_q;
    logic [T-1:0]     k_q;
    logic [T-1:0]     c_q;
    logic [T-1:0]     n_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             host_grant_q;

    // next-state side effects
    logic             start_ok;
    logic             err_set;
    logic             pass_inc;
    logic [1:0]       err_code_nxt;

    // next values of the registered outputs
    logic             ps_d;
    logic             busy_d;
    logic             grant_d;
    logic             done_d;
    logic             err_d;
    logic [1:0]       code_d;

    logic             pl_set;
    logic             pl_clr;
    logic             last_pass;
    logic             cfg_bad;

    // The engine runs on clk, so pl_status is used without a synchroniser.
    assign pl_set    = (bus.pl_status == T'(1));
    assign pl_clr    = (bus.pl_status == '0);
    // Full-width compare against the latched channel count; n_lat is never 0
    // once a layer has started, so the subtraction cannot wrap.
    assign last_pass = (n_q == n_lat - T'(1));
    assign cfg_bad   = (bus.cfg_k == '0) || (bus.cfg_c == '0) || (bus.cfg_n == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        start_ok     = 1'b0;
        err_set      = 1'b0;
        pass_inc     = 1'b0;
        err_code_nxt = 2'b00;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                // abort beats a simultaneous go; on its own it is a no-op here
                if (bus.go && !bus.abort) begin
                    if (cfg_bad) begin
                        state_nxt    = S_ERR;
                        err_set      = 1'b1;
                        err_code_nxt = 2'b01;
                    end else begin
                        state_nxt = S_LOAD;
                        start_ok  = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                state_nxt = bus.abort ? S_CLEAR_ABORT : S_RUN;
            end

            S_RUN: begin
                state_nxt = bus.abort ? S_CLEAR_ABORT : S_WAIT_SET;
            end

            S_WAIT_SET: begin
                // pl_status is checked before the watchdog so a pass that
                // completes on the expiry cycle still counts as completed
                if (bus.abort) begin
                    state_nxt = S_CLEAR_ABORT;
                end else if (pl_set) begin
                    state_nxt = S_CLEAR;
                end else if (wd == TMO_MAX) begin
                    state_nxt    = S_ERR;
                    err_set      = 1'b1;
                    err_code_nxt = 2'b10;
                end
            end

            S_CLEAR: begin
                // ps_control is already low; an abort still has to wait for
                // the engine to drop pl_status before reporting
                if (bus.abort) begin
                    state_nxt = S_CLEAR_ABORT;
                end else if (pl_clr) begin
                    if (last_pass) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                        pass_inc  = 1'b1;
                    end
                end
            end

            S_CLEAR_ABORT: begin
                if (pl_clr) begin
                    state_nxt    = S_ERR;
                    err_set      = 1'b1;
                    err_code_nxt = 2'b11;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: outputs are derived from the next state and registered,
    // so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_comb begin
        ps_d    = (state_nxt == S_RUN) || (state_nxt == S_WAIT_SET);
        busy_d  = (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                  (state_nxt == S_WAIT_SET) || (state_nxt == S_CLEAR) ||
                  (state_nxt == S_CLEAR_ABORT);
        grant_d = !busy_d;

        done_d  = done_q;
        err_d   = err_q;
        code_d  = err_code_q;

        if (start_ok) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            code_d = 2'b00;
        end else begin
            if (state_nxt == S_DONE) begin
                done_d = 1'b1;
            end
            if (err_set) begin
                err_d  = 1'b1;
                code_d = err_code_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output / configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_control_q <= 1'b0;
            busy_q       <= 1'b0;
            host_grant_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            bias_q       <= '0;
            k_q          <= '0;
            c_q          <= '0;
            n_q          <= '0;
            n_lat        <= '0;
        end else begin
            ps_control_q <= ps_d;
            busy_q       <= busy_d;
            host_grant_q <= grant_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= code_d;

            // config is captured only on an accepted start; later cfg_* changes
            // have no effect until the next layer
            if (start_ok) begin
                bias_q <= bus.cfg_bias;
                k_q    <= bus.cfg_k;
                c_q    <= bus.cfg_c;
                n_lat  <= bus.cfg_n;
                n_q    <= '0;
            end else if (pass_inc) begin
                n_q    <= n_q + T'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-pass watchdog: cleared in RUN, counts WAIT_SET cycles. The layer
    // times out after TMO_MAX+1 WAIT_SET cycles without pl_status.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (state == S_RUN) begin
            wd <= '0;
        end else if (state == S_WAIT_SET) begin
            wd <= wd + TMO_W'(1);
        end
    end

    assign bus.ps_control = {{(T-1){1'b0}}, ps_control_q};
    assign bus.bias       = bias_q;
    assign bus.k_val      = k_q;
    assign bus.c_val      = c_q;
    assign bus.n_val      = n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.host_grant = host_grant_q;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Purpose : self-checking bench for conv_pass_sequencer with a cycle-level engine
//           model; expected pass indices and layer outcomes are queued at go time
//           and compared when ps_control rises / done or err rises.
module tb_conv_pass_sequencer;
    localparam int T   = 32;
    localparam int TMO = 50;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_pass_sequencer_if #(.T(T)) bus();

    conv_pass_sequencer #(
        .T       (T),
        .TMO_W   (20),
        .TMO_MAX (20'd50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- engine model ----------------
    // Raises pl_status eng_delay cycles after seeing ps_control high, clears it
    // eng_hold cycles after seeing ps_control low (hold 0 = next cycle).
    int eng_delay = 20;
    bit eng_never = 1'b0;
    int eng_hold  = 0;
    int eng_cnt   = 0;
    int hold_left = 0;

    initial begin
        bus.pl_status = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.pl_status = '0;
                eng_cnt       = 0;
                hold_left     = eng_hold;
            end else if (bus.ps_control == 32'd1) begin
                if (bus.pl_status == 32'd0) begin
                    eng_cnt++;
                    if (!eng_never && eng_cnt >= eng_delay) bus.pl_status = 32'd1;
                end
                hold_left = eng_hold;
            end else begin
                eng_cnt = 0;
                if (bus.pl_status == 32'd1) begin
                    if (hold_left > 0) hold_left--;
                    else bus.pl_status = 32'd0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    int pass_q[$];
    int end_q[$];
    int rises       = 0;
    bit busy_seen   = 1'b0;
    int hi_len      = 0;
    int last_hi_len = 0;
    bit prev_ps     = 1'b0;
    bit prev_done   = 1'b0;
    bit prev_err    = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.ps_control == 32'd1) begin
                if (!prev_ps) begin
                    hi_len = 1;
                    rises++;
                    if (pass_q.size() == 0) check("pass_unexpected", 1, 0);
                    else check("pass_nval", bus.n_val, pass_q.pop_front());
                end else begin
                    hi_len++;
                end
            end else if (prev_ps) begin
                last_hi_len = hi_len;
            end
            if (bus.done && !prev_done) begin
                if (end_q.size() == 0) check("done_unexpected", 1, 0);
                else check("end_done", 0, end_q.pop_front());
            end
            if (bus.err && !prev_err) begin
                if (end_q.size() == 0) check("err_unexpected", 1, 0);
                else check("end_err_code", bus.err_code, end_q.pop_front());
            end
            prev_ps   = (bus.ps_control == 32'd1);
            prev_done = bus.done;
            prev_err  = bus.err;
        end
    end

    // ---------------- stimulus helpers ----------------
    // exp_end: 0 = done, 1..3 = err_code, -1 = no outcome expected
    task automatic start_layer(input logic [31:0] b, input logic [31:0] k,
                               input logic [31:0] c, input logic [31:0] n,
                               input int exp_end, input int n_passes);
        @(negedge clk);
        bus.cfg_bias = b;
        bus.cfg_k    = k;
        bus.cfg_c    = c;
        bus.cfg_n    = n;
        bus.go       = 1'b1;
        for (int i = 0; i < n_passes; i++) pass_q.push_back(i);
        if (exp_end >= 0) end_q.push_back(exp_end);
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (!bus.busy && (bus.done || bus.err)) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pass(input string tag, input logic [31:0] idx, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (bus.ps_control == 32'd1 && bus.n_val == idx) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    int r0;

    initial begin
        bus.go       = 1'b0;
        bus.abort    = 1'b0;
        bus.cfg_bias = '0;
        bus.cfg_k    = '0;
        bus.cfg_c    = '0;
        bus.cfg_n    = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ps_control", bus.ps_control, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done_err", {bus.done, bus.err, bus.err_code}, 0);
        check("rst_host_grant", bus.host_grant, 1);
        check("rst_nval", bus.n_val, 0);
        reset = 1'b1;
        @(negedge clk);

        // single bias-only pass
        eng_delay = 20;
        r0 = rises;
        start_layer(32'h3F800000, 32'd3, 32'd4, 32'd1, 0, 1);
        check("t1_busy", bus.busy, 1);
        check("t1_grant_low", bus.host_grant, 0);
        wait_end("t1", 500);
        check("t1_done", bus.done, 1);
        check("t1_grant", bus.host_grant, 1);
        check("t1_bias", bus.bias, 32'h3F800000);
        check("t1_kc", {bus.k_val, bus.c_val}, {32'd3, 32'd4});
        check("t1_nval", bus.n_val, 0);
        check("t1_pulses", rises - r0, 1);
        check("t1_hi_len", last_hi_len, 20);

        // three passes
        r0 = rises;
        start_layer(32'h40000000, 32'd5, 32'd6, 32'd3, 0, 3);
        wait_end("t2", 1000);
        check("t2_done", bus.done, 1);
        check("t2_nval", bus.n_val, 2);
        check("t2_pulses", rises - r0, 3);
        check("t2_busy", bus.busy, 0);

        // bad config from DONE: ERR/01, nothing latched, engine untouched
        r0 = rises;
        busy_seen = 1'b0;
        start_layer(32'h1, 32'd7, 32'd0, 32'd2, 1, 0);
        wait_end("t3", 50);
        repeat (3) @(negedge clk);
        check("t3_err", bus.err, 1);
        check("t3_code", bus.err_code, 2'b01);
        check("t3_no_pulse", rises - r0, 0);
        check("t3_no_busy", busy_seen, 0);
        check("t3_k_kept", bus.k_val, 5);

        // watchdog timeout: engine never answers
        eng_never = 1'b1;
        start_layer(32'h2, 32'd3, 32'd3, 32'd2, 2, 1);
        wait_end("t4", 500);
        check("t4_err", bus.err, 1);
        check("t4_code", bus.err_code, 2'b10);
        check("t4_grant", bus.host_grant, 1);
        check("t4_ps_low", bus.ps_control, 0);
        check("t4_hi_len", last_hi_len, TMO + 2);
        eng_never = 1'b0;

        // abort in 5th WAIT_SET cycle of pass 2 while engine holds pl_status
        eng_delay = 6;
        eng_hold  = 3;
        start_layer(32'h3, 32'd3, 32'd3, 32'd3, 3, 2);
        wait_pass("t5_pass2", 32'd1, 500);
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t5_ps_fall", bus.ps_control, 0);
        check("t5_wait_clear", {bus.busy, bus.err}, 2'b10);
        @(negedge clk);
        check("t5_still_wait", bus.err, 0);
        wait_end("t5", 100);
        check("t5_code", bus.err_code, 2'b11);
        check("t5_nval", bus.n_val, 1);
        eng_hold = 0;
        start_layer(32'h4, 32'd3, 32'd3, 32'd1, 0, 1);
        check("t5_restart_nval", bus.n_val, 0);
        wait_end("t5b", 500);
        check("t5b_done", bus.done, 1);

        // config change mid-pass, then async reset mid WAIT_SET
        eng_delay = 30;
        start_layer(32'h5, 32'd9, 32'd3, 32'd2, -1, 1);
        wait_pass("t6_pass1", 32'd0, 100);
        repeat (3) @(negedge clk);
        bus.cfg_k = 32'd11;
        @(negedge clk);
        check("t6_k_held", bus.k_val, 9);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_ps", bus.ps_control, 0);
        check("t6_rst_flags", {bus.busy, bus.done, bus.err, bus.err_code}, 0);
        check("t6_rst_grant", bus.host_grant, 1);
        check("t6_rst_cfg", {bus.k_val, bus.bias}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_ps", bus.ps_control, 0);

        check("sb_pass_empty", pass_q.size(), 0);
        check("sb_end_empty", end_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute guard so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "global timeout");
    end
endmodule
